cmd_uart: RTL and testbench

Host-side serial front end for the logic-analyzer command path. It receives bytes on the UART RX line and assembles pairs of them into 16-bit commands, presenting each with a `cmd`/`cmd_rdy` handshake to the command/configuration stage. It also serializes each 8-bit response that stage issues back onto TX and reports completion with `resp_sent`. It sits directly upstream of the command decoder and is the only block touching the host pins.

---
 rtl/cmd_uart.sv | 184 ++++++++++++++++++
 tb/tb_cmd_uart.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart.sv
// Host-side UART front end: pairs received bytes into 16-bit commands and
// serializes 8-bit responses back onto TX. RX and TX run independently.
module cmd_uart #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [11:0] BaudCnt = 12'(BAUD_DIV);
  localparam logic [11:0] HalfCnt = 12'(BAUD_DIV / 2);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {AsmWaitHi, AsmWaitLo, AsmFull} asm_state_e;
  typedef enum logic {TxIdle, TxBusy} tx_state_e;

  logic        r_rx_meta, r_rx_sync;
  rx_state_e   r_rx_state;
  logic [11:0] r_rx_cnt;
  logic [2:0]  r_rx_bits;
  logic [7:0]  r_rx_shift;
  logic        r_byte_vld;

  asm_state_e  r_asm_state;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;

  tx_state_e   r_tx_state;
  logic [11:0] r_tx_cnt;
  logic [3:0]  r_tx_bits;
  logic [9:0]  r_tx_shift;
  logic        r_tx;
  logic        r_resp_sent;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Counter expiry is cnt == 1, so a load of N samples exactly N cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_byte_vld <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      case (r_rx_state)
        RxIdle: begin
          if (!r_rx_sync) begin
            r_rx_state <= RxStart;
            r_rx_cnt   <= HalfCnt;
          end
        end
        RxStart: begin
          if (r_rx_cnt == 12'd1) begin
            r_rx_cnt  <= BaudCnt;
            r_rx_bits <= '0;
            r_rx_state <= r_rx_sync ? RxIdle : RxData;
          end else begin
            r_rx_cnt <= r_rx_cnt - 12'd1;
          end
        end
        RxData: begin
          if (r_rx_cnt == 12'd1) begin
            r_rx_cnt   <= BaudCnt;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bits  <= r_rx_bits + 3'd1;
            if (r_rx_bits == 3'd7) r_rx_state <= RxStop;
          end else begin
            r_rx_cnt <= r_rx_cnt - 12'd1;
          end
        end
        RxStop: begin
          if (r_rx_cnt == 12'd1) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RxIdle;
            r_byte_vld <= r_rx_sync;
          end else begin
            r_rx_cnt <= r_rx_cnt - 12'd1;
          end
        end
        default: r_rx_state <= RxIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_asm_state <= AsmWaitHi;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
    end else begin
      case (r_asm_state)
        AsmWaitHi: begin
          if (r_byte_vld) begin
            r_cmd[15:8] <= r_rx_shift;
            r_asm_state <= AsmWaitLo;
          end
        end
        AsmWaitLo: begin
          if (r_byte_vld) begin
            r_cmd[7:0]  <= r_rx_shift;
            r_cmd_rdy   <= 1'b1;
            r_asm_state <= AsmFull;
          end
        end
        AsmFull: begin
          // Bytes arriving here are dropped so cmd stays stable for the consumer.
          if (clr_cmd_rdy) begin
            r_cmd_rdy   <= 1'b0;
            r_asm_state <= AsmWaitHi;
          end
        end
        default: r_asm_state <= AsmWaitHi;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state  <= TxIdle;
      r_tx_cnt    <= '0;
      r_tx_bits   <= '0;
      r_tx_shift  <= '0;
      r_tx        <= 1'b1;
      r_resp_sent <= 1'b0;
    end else begin
      // Pulse lands in the last cycle of the stop bit.
      r_resp_sent <= (r_tx_state == TxBusy) && (r_tx_bits == 4'd9) && (r_tx_cnt == 12'd2);
      case (r_tx_state)
        TxIdle: begin
          if (send_resp) begin
            r_tx_shift <= {1'b1, resp, 1'b0};
            r_tx       <= 1'b0;
            r_tx_cnt   <= BaudCnt;
            r_tx_bits  <= '0;
            r_tx_state <= TxBusy;
          end
        end
        TxBusy: begin
          if (r_tx_cnt == 12'd1) begin
            if (r_tx_bits == 4'd9) begin
              r_tx       <= 1'b1;
              r_tx_shift <= '0;
              r_tx_bits  <= '0;
              r_tx_cnt   <= '0;
              r_tx_state <= TxIdle;
            end else begin
              r_tx       <= r_tx_shift[1];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bits  <= r_tx_bits + 4'd1;
              r_tx_cnt   <= BaudCnt;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 12'd1;
          end
        end
        default: r_tx_state <= TxIdle;
      endcase
    end
  end

  assign TX        = r_tx;
  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign resp_sent = r_resp_sent;

endmodule

// File: tb/tb_cmd_uart.sv
// Self-checking bench for cmd_uart at BAUD_DIV=16: command assembly, drop/framing/glitch
// handling, TX framing, back-to-back and full-duplex traffic, and reset.
module tb_cmd_uart;

  localparam int unsigned Baud = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        resp_sent;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];

  always #5 clk = ~clk;

  cmd_uart #(.BAUD_DIV(Baud)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame followed by one idle bit time.
  task automatic rx_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    tick(Baud);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(Baud);
    end
    RX = stop;
    tick(Baud);
    RX = 1'b1;
    tick(Baud);
  endtask

  task automatic expect_cmd(input string name);
    logic [15:0] exp;
    int k = 0;
    while (cmd_rdy !== 1'b1 && k < 4 * Baud) begin
      tick(1);
      k++;
    end
    exp = exp_cmd_q.pop_front();
    n_tests++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: cmd_rdy=%b after timeout, required 1", name, cmd_rdy);
    end else if (cmd !== exp) begin
      n_fail++;
      $display("FAIL %s: cmd=%h, required %h", name, cmd, exp);
    end
  endtask

  task automatic clear_cmd(input string name, input logic [15:0] hold);
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    n_tests++;
    if (cmd_rdy !== 1'b0 || cmd !== hold) begin
      n_fail++;
      $display("FAIL %s: cmd_rdy=%b cmd=%h, required 0 %h", name, cmd_rdy, cmd, hold);
    end
  endtask

  // Sends b, checks every cycle of the frame; optionally pulses send_resp mid-frame.
  task automatic tx_frame(input logic [7:0] b, input int ignore_at);
    logic [9:0] frame;
    logic       exp_tx;
    logic       exp_sent;
    exp_tx_q.push_back(b);
    resp = b;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    resp = 8'h00;
    frame = {1'b1, exp_tx_q.pop_front(), 1'b0};
    for (int c = 1; c <= 10 * Baud; c++) begin
      exp_tx   = frame[(c - 1) / Baud];
      exp_sent = (c == 10 * Baud);
      n_tests++;
      if (TX !== exp_tx || resp_sent !== exp_sent) begin
        n_fail++;
        $display("FAIL tx_%h cycle %0d: TX=%b resp_sent=%b, required %b %b",
                 b, c, TX, resp_sent, exp_tx, exp_sent);
      end
      if (c == ignore_at) begin
        resp = ~b;
        send_resp = 1'b1;
      end else begin
        send_resp = 1'b0;
      end
      tick(1);
    end
    send_resp = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    rst_n = 1'b1;
    tick(1);
    n_tests++;
    if (TX !== 1'b1) begin n_fail++; $display("FAIL reset_tx: %b, required 1", TX); end
    n_tests++;
    if (cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd: %h, required 0000", cmd); end
    n_tests++;
    if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: %b, required 0", cmd_rdy); end
    n_tests++;
    if (resp_sent !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sent: %b, required 0", resp_sent);
    end
  endtask

  task automatic test_rx_cmd();
    exp_cmd_q.push_back(16'h470A);
    rx_byte(8'h47, 1'b1);
    rx_byte(8'h0A, 1'b1);
    expect_cmd("rx_470a");
    clear_cmd("clr_470a", 16'h470A);
  endtask

  task automatic test_drop();
    exp_cmd_q.push_back(16'h1122);
    rx_byte(8'h11, 1'b1);
    rx_byte(8'h22, 1'b1);
    expect_cmd("rx_1122");
    rx_byte(8'h99, 1'b1);
    n_tests++;
    if (cmd !== 16'h1122 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_full: cmd=%h rdy=%b, required 1122 1", cmd, cmd_rdy);
    end
    clear_cmd("clr_1122", 16'h1122);
    exp_cmd_q.push_back(16'h8002);
    rx_byte(8'h80, 1'b1);
    rx_byte(8'h02, 1'b1);
    expect_cmd("rx_8002");
    clear_cmd("clr_8002", 16'h8002);
  endtask

  task automatic test_framing();
    rx_byte(8'h5C, 1'b1);
    rx_byte(8'h77, 1'b0);
    tick(Baud);
    n_tests++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_rdy: cmd_rdy=%b, required 0", cmd_rdy);
    end
    exp_cmd_q.push_back(16'h5C33);
    rx_byte(8'h33, 1'b1);
    expect_cmd("rx_5c33");
    clear_cmd("clr_5c33", 16'h5C33);
  endtask

  task automatic test_glitch();
    RX = 1'b0;
    tick(5);
    RX = 1'b1;
    tick(3 * Baud);
    n_tests++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_rdy: cmd_rdy=%b, required 0", cmd_rdy);
    end
    exp_cmd_q.push_back(16'h1234);
    rx_byte(8'h12, 1'b1);
    rx_byte(8'h34, 1'b1);
    expect_cmd("rx_after_glitch");
    clear_cmd("clr_1234", 16'h1234);
  endtask

  task automatic test_tx();
    tx_frame(8'hA5, 50);
    tick(2);
    n_tests++;
    if (TX !== 1'b1 || resp_sent !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_idle_after: TX=%b resp_sent=%b, required 1 0", TX, resp_sent);
    end
  endtask

  task automatic test_back_to_back();
    tx_frame(8'h3C, 0);
    tx_frame(8'hC3, 0);
    tick(2);
  endtask

  task automatic test_full_duplex();
    exp_cmd_q.push_back(16'h0001);
    fork
      begin
        tx_frame(8'hEE, 0);
        tx_frame(8'h5A, 0);
      end
      begin
        rx_byte(8'h00, 1'b1);
        rx_byte(8'h01, 1'b1);
      end
    join
    expect_cmd("duplex_cmd");
  endtask

  task automatic test_reset_mid_tx();
    int pulses = 0;
    int tx_low = 0;
    resp = 8'h00;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    tick(40);
    n_tests++;
    if (TX !== 1'b0) begin n_fail++; $display("FAIL mid_tx_low: TX=%b, required 0", TX); end
    rst_n = 1'b0;
    tick(1);
    n_tests++;
    if (TX !== 1'b1 || cmd !== 16'h0000 || cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: TX=%b cmd=%h rdy=%b, required 1 0000 0", TX, cmd, cmd_rdy);
    end
    tick(2);
    rst_n = 1'b1;
    for (int c = 0; c < 12 * Baud; c++) begin
      if (resp_sent === 1'b1) pulses++;
      if (TX !== 1'b1) tx_low++;
      tick(1);
    end
    n_tests++;
    if (pulses != 0 || tx_low != 0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: resp_sent pulses=%0d TX low cycles=%0d, required 0 0",
               pulses, tx_low);
    end
  endtask

  initial begin
    test_reset();
    test_rx_cmd();
    test_drop();
    test_framing();
    test_glitch();
    test_tx();
    test_back_to_back();
    test_full_duplex();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
